// File: rtl/msg_pkg.sv
// Shared message types for the extractor and its output buffer.
// Byte masks are right-justified runs of ones.
package msg_pkg;

  localparam int MSG_DATA_W = 256;
  localparam int MSG_MASK_W = 32;
  localparam int MSG_LEN_W  = 6;

  typedef struct packed {
    logic [MSG_DATA_W-1:0] data;
    logic [MSG_MASK_W-1:0] mask;
    logic [MSG_LEN_W-1:0]  len;
  } msg_t;

  // All-ones wraps to zero on the increment, so a full mask is legal.
  function automatic logic mask_is_contiguous(
    input logic [MSG_MASK_W-1:0] m
  );
    logic [MSG_MASK_W-1:0] p;
    p = m + MSG_MASK_W'(1);
    return (m != '0) && ((m & p) == '0);
  endfunction

endpackage

// File: rtl/msg_popcount32.sv
// Combinational 32-bit popcount producing a message byte length.
// A full mask yields 6'd32.
module msg_popcount32
  import msg_pkg::*;
(
  input  logic [MSG_MASK_W-1:0] mask,
  output logic [MSG_LEN_W-1:0]  len
);

  always_comb begin
    len = '0;
    for (int i = 0; i < MSG_MASK_W; i++) begin
      len = len + MSG_LEN_W'(mask[i]);
    end
  end

endmodule

// File: rtl/message_out_buffer.sv
// First-word-fall-through buffer between the message extractor and its consumer.
// Full/empty come from the level register, never from pointer compare.
module message_out_buffer
  import msg_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [MSG_DATA_W-1:0] in_data,
  input  logic [MSG_MASK_W-1:0] in_bytemask,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [MSG_DATA_W-1:0] out_data,
  output logic [MSG_MASK_W-1:0] out_bytemask,
  output logic [MSG_LEN_W-1:0]  out_length,
  output logic [AW:0]           level,
  output logic                  overflow,
  output logic                  mask_error,
  output logic [CNT_W-1:0]      msg_count,
  output logic [CNT_W-1:0]      drop_count
);

  msg_t                 mem [DEPTH];
  msg_t                 head;
  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        wr_ptr;
  logic [MSG_LEN_W-1:0] wr_len;
  logic                 good;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 drop_bad;
  logic                 drop_full;

  msg_popcount32 u_pc (
    .mask (in_bytemask),
    .len  (wr_len)
  );

  assign good      = mask_is_contiguous(in_bytemask);
  assign full      = (level == (AW+1)'(DEPTH));
  assign out_valid = (level != '0);
  assign pop       = out_valid & out_ready;
  // A pop in the same cycle frees the slot the push lands in.
  assign push      = in_valid & good & (!full | pop);
  assign drop_bad  = in_valid & !good;
  assign drop_full = in_valid & good & full & !pop;

  assign head         = mem[rd_ptr];
  assign out_data     = head.data;
  assign out_bytemask = head.mask;
  assign out_length   = head.len;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      mask_error <= 1'b0;
      msg_count  <= '0;
      drop_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{data: in_data, mask: in_bytemask, len: wr_len};
        wr_ptr      <= wr_ptr + AW'(1);
        if (msg_count != '1) begin
          msg_count <= msg_count + CNT_W'(1);
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        level <= level + (AW+1)'(1);
      end else if (pop && !push) begin
        level <= level - (AW+1)'(1);
      end
      if (drop_bad) begin
        mask_error <= 1'b1;
      end
      if (drop_full) begin
        overflow <= 1'b1;
      end
      if ((drop_bad || drop_full) && drop_count != '1) begin
        drop_count <= drop_count + CNT_W'(1);
      end
    end
  end

endmodule
